// File: rtl/moore_seq_controller_pkg.sv
// moore_seq_controller_pkg: shared state encoding and pattern-match transition helper
package moore_seq_controller_pkg;
  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13, S14, S15
  } state_t;
  localparam state_t S_DET = S8;
  function automatic logic [3:0] kmp_next(input logic [7:0] p, input int k, input logic b);
    logic [8:0] s;
    logic ok;
    int n;
    kmp_next = 4'd0;
    s = '0;
    n = k + 1;
    for (int i = 0; i < 8; i++)
      if (i < k) s[4'(i)] = p[3'(7 - i)];
    s[4'(k)] = b;
    for (int j = 1; j <= 8; j++) begin
      if (j <= n) begin
        ok = 1'b1;
        for (int i = 0; i < 8; i++)
          if (i < j)
            if (s[4'(n - j + i)] != p[3'(7 - i)]) ok = 1'b0;
        if (ok) kmp_next = 4'(j);
      end
    end
  endfunction
endpackage

// File: rtl/seq_next_state.sv
// seq_next_state: elaboration-built match-length transition table for the serial pattern
module seq_next_state
  import moore_seq_controller_pkg::*;
#(
  parameter logic [7:0] PATTERN = 8'b1011_0110
) (
  input  logic [3:0] k,
  input  logic       b,
  output logic [3:0] nxt
);
  logic [3:0] tbl [0:17];
  for (genvar i = 0; i < 9; i++) begin : g_k
    for (genvar j = 0; j < 2; j++) begin : g_b
      assign tbl[2*i+j] = kmp_next(PATTERN, i, 1'(j));
    end
  end
  assign nxt = (k <= 4'd8) ? tbl[{k, b}] : S0;
endmodule

// File: rtl/moore_seq_controller.sv
// moore_seq_controller: handshaked serial pattern detector with post-detect hold and saturating count
module moore_seq_controller
  import moore_seq_controller_pkg::*;
#(
  parameter logic [7:0] PATTERN = 8'b1011_0110,
  parameter int         HOLD    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       InValid,
  input  logic       InBit,
  output logic       InReady,
  output logic [3:0] State,
  output logic       Detect,
  output logic [7:0] DetCount
);
  localparam state_t LAST = state_t'(8 + HOLD);
  state_t     st;
  logic [3:0] nxt;
  logic       match;
  logic       accept;
  assign match   = (st < S8) || (st == S_DET && HOLD == 0);
  assign InReady = match && !Reset && !Clear;
  assign accept  = InValid && InReady;
  seq_next_state #(.PATTERN(PATTERN)) u_next (
    .k  (st),
    .b  (InBit),
    .nxt(nxt)
  );
  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      st       <= S0;
      DetCount <= '0;
    end else if (match) begin
      if (accept) begin
        st <= state_t'(nxt);
        if (nxt == 4'd8 && DetCount != 8'hff) DetCount <= DetCount + 8'd1;
      end
    end else begin
      st <= (st < LAST) ? state_t'(st + 4'd1) : S0;
    end
  end
  assign State  = st;
  assign Detect = (st == S_DET);
endmodule

// File: tb/tb_moore_seq_controller.sv
// tb_moore_seq_controller: directed scoreboard bench for HOLD=2 and HOLD=0 controllers
module tb_moore_seq_controller;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Clear = 1'b0;
  logic        InValid = 1'b0;
  logic        InBit = 1'b0;
  logic        rdy2, rdy0, det2, det0;
  logic [3:0]  st2, st0;
  logic [7:0]  cnt2, cnt0;
  logic        sel = 1'b0;
  logic [7:0]  pat = 8'b1011_0110;
  logic [11:0] sb [$];
  int          total = 0;
  int          bad = 0;
  always #5 Clk = ~Clk;
  moore_seq_controller #(.HOLD(2)) u_h2 (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InBit(InBit),
    .InReady(rdy2), .State(st2), .Detect(det2), .DetCount(cnt2)
  );
  moore_seq_controller #(.HOLD(0)) u_h0 (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InBit(InBit),
    .InReady(rdy0), .State(st0), .Detect(det0), .DetCount(cnt0)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic b, input logic [3:0] es, input logic [7:0] ec, input logic er);
    logic [11:0] e;
    @(negedge Clk);
    InValid = v;
    InBit = b;
    #1;
    chk("in_ready", 32'(sel ? rdy0 : rdy2), 32'(er));
    sb.push_back({es, ec});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk("state", 32'(sel ? st0 : st2), 32'(e[11:8]));
    chk("detect", 32'(sel ? det0 : det2), 32'(e[11:8] == 4'd8));
    chk("det_count", 32'(sel ? cnt0 : cnt2), 32'(e[7:0]));
  endtask
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Clear = 1'b0;
    InValid = 1'b1;
    #1;
    chk("ready_in_reset", 32'(sel ? rdy0 : rdy2), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    InValid = 1'b0;
    #1;
    chk("reset_state", 32'(sel ? st0 : st2), 32'd0);
    chk("reset_count", 32'(sel ? cnt0 : cnt2), 32'd0);
    chk("reset_detect", 32'(sel ? det0 : det2), 32'd0);
    chk("reset_ready", 32'(sel ? rdy0 : rdy2), 32'd1);
  endtask
  initial begin
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, pat[3'(7 - i)], 4'(i + 1), (i == 7) ? 8'd1 : 8'd0, 1'b1);
    step(1'b1, 1'b1, 4'd9, 8'd1, 1'b0);
    step(1'b1, 1'b1, 4'd10, 8'd1, 1'b0);
    step(1'b1, 1'b1, 4'd0, 8'd1, 1'b0);
    step(1'b1, 1'b1, 4'd1, 8'd1, 1'b1);
    sel = 1'b1;
    do_reset();
    step(1'b1, 1'b1, 4'd1, 8'd0, 1'b1);
    step(1'b1, 1'b0, 4'd2, 8'd0, 1'b1);
    step(1'b1, 1'b1, 4'd3, 8'd0, 1'b1);
    step(1'b1, 1'b0, 4'd2, 8'd0, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, pat[3'(7 - i)], 4'(i + 1), (i == 7) ? 8'd1 : 8'd0, 1'b1);
    step(1'b1, 1'b1, 4'd6, 8'd1, 1'b1);
    step(1'b1, 1'b1, 4'd7, 8'd1, 1'b1);
    step(1'b1, 1'b0, 4'd8, 8'd2, 1'b1);
    step(1'b0, 1'b0, 4'd8, 8'd2, 1'b1);
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[3'(7 - i)], 4'(i + 1), (i == 7) ? 8'd1 : 8'd0, 1'b1);
      if (i < 7) step(1'b0, ~pat[3'(7 - i)], 4'(i + 1), 8'd0, 1'b1);
    end
    step(1'b1, 1'b0, 4'd9, 8'd1, 1'b0);
    step(1'b1, 1'b0, 4'd10, 8'd1, 1'b0);
    step(1'b1, 1'b1, 4'd0, 8'd1, 1'b0);
    step(1'b1, 1'b1, 4'd1, 8'd1, 1'b1);
    step(1'b1, 1'b0, 4'd2, 8'd1, 1'b1);
    step(1'b1, 1'b1, 4'd3, 8'd1, 1'b1);
    step(1'b1, 1'b1, 4'd4, 8'd1, 1'b1);
    step(1'b1, 1'b0, 4'd5, 8'd1, 1'b1);
    step(1'b1, 1'b1, 4'd6, 8'd1, 1'b1);
    Clear = 1'b1;
    step(1'b1, 1'b1, 4'd0, 8'd0, 1'b0);
    Clear = 1'b0;
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    step(1'b1, 1'b1, 4'd1, 8'd0, 1'b1);
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1'b1, pat[3'(7 - i)], 4'(i + 1), (i == 7) ? 8'd1 : 8'd0, 1'b1);
    for (int n = 2; n <= 300; n++) begin
      step(1'b1, 1'b1, 4'd6, (n - 1 > 255) ? 8'd255 : 8'(n - 1), 1'b1);
      step(1'b1, 1'b1, 4'd7, (n - 1 > 255) ? 8'd255 : 8'(n - 1), 1'b1);
      step(1'b1, 1'b0, 4'd8, (n > 255) ? 8'd255 : 8'(n), 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
